perf_monitor_unit: RTL and testbench

- In-design performance monitor attached to the MIPS_Processor pipeline.
- Consumes the IF-stage PC and instruction, the hazard-detection flag and the WB write-enable.
- Produces cycle, fetched-instruction, stall and commit counters plus a run-completion flag.
- Lets CPI for forwarding on/off be read from hardware rather than from a bench.

---
 rtl/perf_monitor_unit.sv | 188 ++++++++++++++++++
 tb/tb_perf_monitor_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor_unit.sv
// Pipeline performance monitor: counts cycles, fetched instructions, stall
// cycles and commits for one program run, and stops on the terminal
// instruction, an instruction target, or a cycle timeout.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; counters hold (zero after reset/clear)
// RUN   | counting on every clock edge
// DONE  | run finished; counters frozen, done_reason valid
module perf_monitor_unit #(
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] TERM_INST = 32'hA800FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] target_instrs,
    input  logic [CNT_W-1:0] max_cycles,
    input  logic             forwarding_EN,
    input  logic             hazard_detected,
    input  logic [31:0]      PC_IF,
    input  logic [31:0]      inst_IF,
    input  logic             WB_EN_WB,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instrs,
    output logic [CNT_W-1:0] stalls,
    output logic [CNT_W-1:0] commits,
    output logic             running,
    output logic             done,
    output logic [1:0]       done_reason,
    output logic             fwd_mode,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] R_NONE    = 2'b00;
    localparam logic [1:0] R_TERM    = 2'b01;
    localparam logic [1:0] R_TARGET  = 2'b10;
    localparam logic [1:0] R_TIMEOUT = 2'b11;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cycles_nxt, instrs_nxt, stalls_nxt, commits_nxt;
    logic [31:0]      prev_pc, prev_pc_nxt;
    logic             prev_pc_valid, prev_pc_valid_nxt;
    logic [1:0]       reason_nxt;
    logic             fwd_nxt, sat_nxt;

    logic             fetch;
    logic [1:0]       term_reason;
    logic [CNT_W:0]   cyc_r, ins_r, stl_r, com_r;

    // Saturating increment; the top bit flags an increment blocked at all-ones.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
        logic [CNT_W:0] r;
        r = {1'b0, v};
        if (en) begin
            if (&v) r[CNT_W] = 1'b1;
            else    r[CNT_W-1:0] = v + CNT_W'(1);
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and next-counter logic: clear beats start beats RUN update.
    always_comb begin
        state_nxt         = state;
        cycles_nxt        = cycles;
        instrs_nxt        = instrs;
        stalls_nxt        = stalls;
        commits_nxt       = commits;
        prev_pc_nxt       = prev_pc;
        prev_pc_valid_nxt = prev_pc_valid;
        reason_nxt        = done_reason;
        fwd_nxt           = fwd_mode;
        sat_nxt           = sat;
        fetch             = 1'b0;
        term_reason       = R_NONE;
        cyc_r             = '0;
        ins_r             = '0;
        stl_r             = '0;
        com_r             = '0;

        if (clear) begin
            state_nxt         = IDLE;
            cycles_nxt        = '0;
            instrs_nxt        = '0;
            stalls_nxt        = '0;
            commits_nxt       = '0;
            prev_pc_nxt       = '0;
            prev_pc_valid_nxt = 1'b0;
            reason_nxt        = R_NONE;
            fwd_nxt           = 1'b0;
            sat_nxt           = 1'b0;
        end else if (start) begin
            state_nxt         = RUN;
            cycles_nxt        = '0;
            instrs_nxt        = '0;
            stalls_nxt        = '0;
            commits_nxt       = '0;
            prev_pc_nxt       = '0;
            prev_pc_valid_nxt = 1'b0;
            reason_nxt        = R_NONE;
            fwd_nxt           = forwarding_EN;
            sat_nxt           = 1'b0;
        end else if (state == RUN) begin
            // A new fetch is a PC change while IF is not frozen; the first
            // unfrozen cycle of a run always counts as a fetch. Zero
            // instructions are bubbles: they move prev_pc but are not counted.
            if (!hazard_detected) begin
                if (!prev_pc_valid) begin
                    prev_pc_nxt       = PC_IF;
                    prev_pc_valid_nxt = 1'b1;
                    fetch             = (inst_IF != 32'd0);
                end else if (PC_IF != prev_pc) begin
                    prev_pc_nxt = PC_IF;
                    fetch       = (inst_IF != 32'd0);
                end
            end

            cyc_r = sat_inc(cycles,  1'b1);
            ins_r = sat_inc(instrs,  fetch);
            stl_r = sat_inc(stalls,  hazard_detected);
            com_r = sat_inc(commits, WB_EN_WB);

            cycles_nxt  = cyc_r[CNT_W-1:0];
            instrs_nxt  = ins_r[CNT_W-1:0];
            stalls_nxt  = stl_r[CNT_W-1:0];
            commits_nxt = com_r[CNT_W-1:0];
            sat_nxt     = sat | cyc_r[CNT_W] | ins_r[CNT_W]
                              | stl_r[CNT_W] | com_r[CNT_W];

            // Stop conditions use this edge's post-increment counts.
            if (target_instrs == '0 && inst_IF == TERM_INST)
                term_reason = R_TERM;
            else if (target_instrs != '0 && instrs_nxt >= target_instrs)
                term_reason = R_TARGET;
            else if (max_cycles != '0 && cycles_nxt >= max_cycles)
                term_reason = R_TIMEOUT;

            if (term_reason != R_NONE) begin
                state_nxt  = DONE;
                reason_nxt = term_reason;
            end
        end
    end

    // Counter and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles        <= '0;
            instrs        <= '0;
            stalls        <= '0;
            commits       <= '0;
            prev_pc       <= '0;
            prev_pc_valid <= 1'b0;
            done_reason   <= R_NONE;
            fwd_mode      <= 1'b0;
            sat           <= 1'b0;
        end else begin
            cycles        <= cycles_nxt;
            instrs        <= instrs_nxt;
            stalls        <= stalls_nxt;
            commits       <= commits_nxt;
            prev_pc       <= prev_pc_nxt;
            prev_pc_valid <= prev_pc_valid_nxt;
            done_reason   <= reason_nxt;
            fwd_mode      <= fwd_nxt;
            sat           <= sat_nxt;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_perf_monitor_unit.sv
// Testbench for perf_monitor_unit: directed scenarios plus randomized runs
// checked against a behavioural model of the counting rules.
module tb_perf_monitor_unit;

    localparam logic [31:0] TERM = 32'hA800FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] target_instrs = '0;
    logic [31:0] max_cycles = '0;
    logic        forwarding_EN = 1'b0;
    logic        hazard_detected = 1'b0;
    logic [31:0] PC_IF = '0;
    logic [31:0] inst_IF = '0;
    logic        WB_EN_WB = 1'b0;

    logic [31:0] cycles, instrs, stalls, commits;
    logic        running, done, fwd_mode, sat;
    logic [1:0]  done_reason;

    logic [3:0]  target4 = '0;
    logic [3:0]  max4 = '0;
    logic [3:0]  cycles4, instrs4, stalls4, commits4;
    logic        running4, done4, fwd_mode4, sat4;
    logic [1:0]  done_reason4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    perf_monitor_unit dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .target_instrs(target_instrs), .max_cycles(max_cycles),
        .forwarding_EN(forwarding_EN), .hazard_detected(hazard_detected),
        .PC_IF(PC_IF), .inst_IF(inst_IF), .WB_EN_WB(WB_EN_WB),
        .cycles(cycles), .instrs(instrs), .stalls(stalls), .commits(commits),
        .running(running), .done(done), .done_reason(done_reason),
        .fwd_mode(fwd_mode), .sat(sat)
    );

    perf_monitor_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .target_instrs(target4), .max_cycles(max4),
        .forwarding_EN(forwarding_EN), .hazard_detected(hazard_detected),
        .PC_IF(PC_IF), .inst_IF(inst_IF), .WB_EN_WB(WB_EN_WB),
        .cycles(cycles4), .instrs(instrs4), .stalls(stalls4), .commits(commits4),
        .running(running4), .done(done4), .done_reason(done_reason4),
        .fwd_mode(fwd_mode4), .sat(sat4)
    );

    // Reference model (32-bit instance): mode 0 idle, 1 run, 2 done.
    int          m_mode;
    logic [31:0] m_cyc, m_ins, m_stl, m_com, m_ppc;
    bit          m_pv, m_fwd, m_sat;
    logic [1:0]  m_reason;

    function automatic logic [31:0] bump(input logic [31:0] v, input bit en);
        if (!en) return v;
        if (v == 32'hFFFF_FFFF) begin
            m_sat = 1'b1;
            return v;
        end
        return v + 32'd1;
    endfunction

    task automatic model_zero();
        m_mode = 0; m_cyc = 0; m_ins = 0; m_stl = 0; m_com = 0;
        m_ppc = 0; m_pv = 0; m_fwd = 0; m_reason = 0; m_sat = 0;
    endtask

    task automatic model_step();
        bit f;
        if (clear) begin
            model_zero();
        end else if (start) begin
            m_mode = 1; m_cyc = 0; m_ins = 0; m_stl = 0; m_com = 0;
            m_pv = 0; m_fwd = forwarding_EN; m_reason = 0; m_sat = 0;
        end else if (m_mode == 1) begin
            f = 0;
            if (!hazard_detected) begin
                if (!m_pv || PC_IF != m_ppc) f = (inst_IF != 0);
                if (!m_pv || PC_IF != m_ppc) m_ppc = PC_IF;
                m_pv = 1;
            end
            m_cyc = bump(m_cyc, 1'b1);
            m_ins = bump(m_ins, f);
            m_stl = bump(m_stl, hazard_detected);
            m_com = bump(m_com, WB_EN_WB);
            if (target_instrs == 0 && inst_IF == TERM) m_reason = 2'b01;
            else if (target_instrs != 0 && m_ins >= target_instrs) m_reason = 2'b10;
            else if (max_cycles != 0 && m_cyc >= max_cycles) m_reason = 2'b11;
            if (m_reason != 0) m_mode = 2;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit fwd);
        forwarding_EN = fwd;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        tests_run++;
        if ({cycles, instrs, stalls, commits, running, done, done_reason, fwd_mode, sat} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got c=%0d i=%0d s=%0d m=%0d run=%b done=%b r=%b, expected all zero",
                     cycles, instrs, stalls, commits, running, done, done_reason);
        end
        rst = 1'b0;
        model_zero();
        inst_IF = 32'h1; PC_IF = 0;
        pulse_start(1'b1);
        for (int i = 0; i < 3; i++) begin
            PC_IF = 4 * i; inst_IF = 32'h10 + i; WB_EN_WB = 1'b1;
            tick();
        end
        tests_run++;
        if (cycles !== 3 || commits !== 3 || running !== 1'b1 || fwd_mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_run: got c=%0d m=%0d run=%b fwd=%b, expected 3 3 1 1",
                     cycles, commits, running, fwd_mode);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({cycles, instrs, stalls, commits, running, done, done_reason, fwd_mode, sat} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got c=%0d i=%0d run=%b r=%b fwd=%b, expected all zero",
                     cycles, instrs, running, done_reason, fwd_mode);
        end
        rst = 1'b0;
        WB_EN_WB = 1'b0;
        model_zero();
        tick();
    endtask

    task automatic test_terminal();
        logic [31:0] snap [4];
        target_instrs = 0; max_cycles = 0; hazard_detected = 0;
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            PC_IF = 4 * i; inst_IF = 32'h2000_0001 + i;
            tick();
        end
        PC_IF = 20; inst_IF = TERM;
        tick();
        tests_run++;
        if (done !== 1'b1 || running !== 1'b0 || cycles !== 6 || instrs !== 6 ||
            stalls !== 0 || done_reason !== 2'b01) begin
            tests_failed++;
            $display("FAIL terminal: got done=%b c=%0d i=%0d s=%0d r=%b, expected 1 6 6 0 01",
                     done, cycles, instrs, stalls, done_reason);
        end
        snap[0] = cycles; snap[1] = instrs; snap[2] = stalls; snap[3] = commits;
        for (int i = 0; i < 5; i++) begin
            PC_IF = 100 + 4 * i; inst_IF = $urandom | 1; WB_EN_WB = 1'b1;
            hazard_detected = i[0];
            tick();
        end
        hazard_detected = 0; WB_EN_WB = 0;
        tests_run++;
        if (cycles !== 6 || instrs !== 6 || stalls !== 0 || commits !== 0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_frozen: got c=%0d i=%0d s=%0d m=%0d done=%b, expected 6 6 0 0 1",
                     cycles, instrs, stalls, commits, done);
        end
    endtask

    task automatic test_stall();
        pulse_start(1'b0);
        PC_IF = 0; inst_IF = 32'h11; tick();
        PC_IF = 4; inst_IF = 32'h22; tick();
        hazard_detected = 1; tick(); tick();
        hazard_detected = 0; PC_IF = 8; inst_IF = 32'h33; tick();
        tests_run++;
        if (stalls !== 2 || instrs !== 3 || cycles !== 5 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall: got s=%0d i=%0d c=%0d run=%b, expected 2 3 5 1",
                     stalls, instrs, cycles, running);
        end
        do_clear();
    endtask

    task automatic test_target();
        target_instrs = 2;
        pulse_start(1'b0);
        PC_IF = 0; inst_IF = 32'h44; tick();
        PC_IF = 4; inst_IF = 32'h0;  tick();
        tests_run++;
        if (running !== 1'b1 || instrs !== 1) begin
            tests_failed++;
            $display("FAIL target_bubble: got run=%b i=%0d, expected 1 1", running, instrs);
        end
        PC_IF = 8; inst_IF = 32'h55; tick();
        tests_run++;
        if (done !== 1'b1 || instrs !== 2 || cycles !== 3 || done_reason !== 2'b10) begin
            tests_failed++;
            $display("FAIL target: got done=%b i=%0d c=%0d r=%b, expected 1 2 3 10",
                     done, instrs, cycles, done_reason);
        end
        target_instrs = 0;
    endtask

    task automatic test_timeout();
        max_cycles = 4;
        pulse_start(1'b1);
        PC_IF = 32'h40; inst_IF = 32'h66;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (running !== 1'b1 || cycles !== 3) begin
            tests_failed++;
            $display("FAIL pre_timeout: got run=%b c=%0d, expected 1 3", running, cycles);
        end
        tick();
        tests_run++;
        if (done !== 1'b1 || cycles !== 4 || instrs !== 1 || done_reason !== 2'b11 || fwd_mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout: got done=%b c=%0d i=%0d r=%b fwd=%b, expected 1 4 1 11 1",
                     done, cycles, instrs, done_reason, fwd_mode);
        end
        max_cycles = 0;
    endtask

    task automatic test_random();
        logic [31:0] pcs [4];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
        for (int run = 0; run < 10; run++) begin
            target_instrs = $urandom_range(0, 6);
            max_cycles = $urandom_range(0, 14);
            PC_IF = pcs[$urandom_range(0, 3)];
            inst_IF = $urandom;
            pulse_start(1'($urandom_range(0, 1)));
            for (int c = 0; c < 25; c++) begin
                hazard_detected = ($urandom_range(0, 2) == 0);
                PC_IF = pcs[$urandom_range(0, 3)];
                case ($urandom_range(0, 14))
                    0:       inst_IF = TERM;
                    1, 2:    inst_IF = 32'h0;
                    default: inst_IF = ($urandom | 32'h1) & 32'h7FFF_FFFF;
                endcase
                WB_EN_WB = 1'($urandom_range(0, 1));
                clear = ($urandom_range(0, 39) == 0);
                tick();
                clear = 1'b0;
                tests_run++;
                if ({cycles, instrs, stalls, commits, running, done, done_reason, fwd_mode, sat} !==
                    {m_cyc, m_ins, m_stl, m_com, m_mode == 1, m_mode == 2, m_reason, m_fwd, m_sat}) begin
                    tests_failed++;
                    $display("FAIL random run%0d cyc%0d: got c=%0d i=%0d s=%0d m=%0d run=%b done=%b r=%b fwd=%b sat=%b, expected c=%0d i=%0d s=%0d m=%0d mode=%0d r=%b fwd=%b sat=%b",
                             run, c, cycles, instrs, stalls, commits, running, done, done_reason, fwd_mode, sat,
                             m_cyc, m_ins, m_stl, m_com, m_mode, m_reason, m_fwd, m_sat);
                end
            end
        end
        target_instrs = 0; max_cycles = 0; hazard_detected = 0; WB_EN_WB = 0;
    endtask

    task automatic test_saturation();
        do_clear();
        PC_IF = 32'h80; inst_IF = 32'h77; hazard_detected = 0;
        pulse_start(1'b0);
        WB_EN_WB = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (commits4 !== 4'd10 || sat4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_early: got m=%0d sat=%b, expected 10 0", commits4, sat4);
        end
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (commits4 !== 4'd15 || cycles4 !== 4'd15 || sat4 !== 1'b1 || running4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturation: got m=%0d c=%0d sat=%b run=%b, expected 15 15 1 1",
                     commits4, cycles4, sat4, running4);
        end
        WB_EN_WB = 1'b0;
        do_clear();
        tests_run++;
        if ({cycles4, instrs4, stalls4, commits4, running4, done4, done_reason4, fwd_mode4, sat4} !== '0) begin
            tests_failed++;
            $display("FAIL clear: got c=%0d m=%0d run=%b sat=%b, expected all zero",
                     cycles4, commits4, running4, sat4);
        end
        pulse_start(1'b1);
        tests_run++;
        if (fwd_mode4 !== 1'b1 || running4 !== 1'b1 || cycles4 !== 4'd0 || fwd_mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwd_latch: got fwd4=%b run4=%b c4=%0d fwd=%b, expected 1 1 0 1",
                     fwd_mode4, running4, cycles4, fwd_mode);
        end
    endtask

    initial begin
        model_zero();
        test_reset();
        test_terminal();
        test_stall();
        test_target();
        test_timeout();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
